uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//   Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
//   Supports configurable data width, parity and stop bits, and a runtime baud divisor.
//   A one-entry holding buffer with a valid/ready handshake allows back-to-back frames with no idle gap.
//   Sits between the host-side byte source and the serial TX pin.
// PARAMETERS
//   DATA_BITS  8   data bits per frame, legal 5..9, sent LSB first
//   PARITY     0   0 = none, 1 = even, 2 = odd
//   STOP_BITS  1   stop bits per frame, legal 1 or 2
//   DIV_W      16  width of the baud divisor input
// PORTS
//   clk        in   1          system clock
//   rst        in   1          synchronous reset, active-high
//   cfg_div    in   DIV_W      bit period = cfg_div+1 clk cycles; sampled at each frame load
//   s_valid    in   1          tx_data is valid
//   s_ready    out  1          block can accept a word (holding buffer empty)
//   tx_data    in   9          frame data; bits [8:DATA_BITS] are ignored
//   tx         out  1          serial line, idle high
//   busy       out  1          frame in progress or holding buffer occupied
//   tx_done    out  1          one-cycle pulse when a frame's last stop bit ends
// BEHAVIOUR
//   Clock and reset
//   - One clock (clk). rst is synchronous and active-high.
//   - Reset values: tx=1, s_ready=1, busy=0, tx_done=0.
//   - Reset also clears state to IDLE, the holding buffer, and the bit and baud counters.
//   - rst asserted mid-frame: tx=1 after the next edge, frame abandoned, no tx_done pulse.
//   Handshake and buffering
//   - A word transfers on any edge where s_valid && s_ready.
//   - Accepted words go to the holding buffer; s_ready = !buf_full (registered).
//   - If the shifter is IDLE at the accept edge, the word goes straight to the shifter; the buffer stays empty.
//   - Accept on the same edge the shifter frees the buffer: both happen, no word is lost.
//   State machine: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> reload or IDLE
//   - Load: latch the data word and cfg_div, clear the baud counter, enter START.
//   - Timing: tx is registered. tx=0 from the edge after the load edge. Every bit lasts exactly cfg_div+1 cycles.
//   - DATA: sends DATA_BITS bits, bit 0 first.
//   - PARITY: even sends ^data; odd sends ~^data.
//   - STOP: sends STOP_BITS bit-periods of 1.
//   - End of STOP with buffer full: load the buffer word directly (its start bit follows with no idle cycle) and clear the buffer.
//   - End of STOP with buffer empty: go to IDLE.
//   - tx_done is high for exactly one cycle, at the end of each frame's STOP period.
//   - Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * (cfg_div+1) cycles.
//   Arithmetic and configuration
//   - The baud counter is DIV_W bits wide and counts 0..cfg_div_latched. It never wraps past the latched value.
//   - cfg_div=0 is legal: one bit per clock.
//   - Changing cfg_div mid-frame has no effect until the next load.
//   - busy = (state != IDLE) || buf_full.
// TESTING
//   1. Defaults, cfg_div=3, send 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1 each for 4 clk; 40 cycles; one tx_done.
//   2. PARITY=1, DATA_BITS=7, STOP_BITS=2, send 0x35 -> parity bit 0; frame 11*(cfg_div+1) cycles.
//   3. PARITY=2, send 0x00 -> parity bit 1; send 0x01 -> parity bit 0.
//   4. Hold s_valid with 0x11, 0x22, 0x33 -> 0x22 buffered and s_ready low until 0x22 loads; 3 frames, no idle gap.
//   5. rst asserted in DATA bit 4 -> tx=1 next cycle, s_ready=1, busy=0, no tx_done; new frame sends cleanly.
//   6. cfg_div changes 3 -> 9 mid-frame -> current frame stays 4 clk/bit; next frame 10 clk/bit.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data, optional parity, 1-2 stop bits,
// runtime baud divisor, and a one-word holding buffer for gap-free back-to-back frames.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [8:0]       tx_data,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [8:0] DMASK     = 9'((1 << DATA_BITS) - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  state_t           state;
  logic [8:0]       shreg, buf_q;
  logic             buf_full, par_q;
  logic [DIV_W-1:0] div_q, baud_cnt;
  logic [3:0]       bit_cnt;

  logic       accept, baud_end, frame_end, direct, from_buf, load;
  logic [8:0] load_word;

  assign s_ready   = !buf_full;
  assign busy      = (state != IDLE) || buf_full;
  assign accept    = s_valid && s_ready;
  assign baud_end  = (baud_cnt == div_q);
  assign frame_end = (state == STOP) && baud_end && (bit_cnt == LAST_STOP);
  // A word bypasses the buffer whenever the shifter is free at the accept edge,
  // including the edge where the current frame finishes with nothing queued.
  assign direct    = accept && ((state == IDLE) || (frame_end && !buf_full));
  assign from_buf  = frame_end && buf_full;
  assign load      = direct || from_buf;
  assign load_word = (from_buf ? buf_q : tx_data) & DMASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      buf_full <= 1'b0;
      buf_q    <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      tx_done <= frame_end;

      if (accept && !direct) begin
        buf_q    <= tx_data;
        buf_full <= 1'b1;
      end else if (from_buf) begin
        buf_full <= 1'b0;
      end

      if (load) begin
        state    <= START;
        shreg    <= load_word;
        par_q    <= (^load_word) ^ (PARITY == 2);
        div_q    <= cfg_div;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        tx       <= 1'b0;
      end else if (state != IDLE) begin
        if (!baud_end) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          case (state)
            START: begin
              state <= DATA;
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[8:1]};
            end
            DATA: begin
              if (bit_cnt == LAST_DATA) begin
                bit_cnt <= '0;
                if (PARITY != 0) begin
                  state <= PAR;
                  tx    <= par_q;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= shreg[0];
                shreg   <= {1'b0, shreg[8:1]};
              end
            end
            PAR: begin
              state <= STOP;
              tx    <= 1'b1;
            end
            STOP: begin
              if (bit_cnt == LAST_STOP) state <= IDLE;
              else bit_cnt <= bit_cnt + 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four parameter sets share one stimulus stream; each has a
// frame-level scoreboard predicting the serial waveform, handshake and status per cycle.
module tb_uart_tx_cfg;

  localparam int N = 4;
  localparam int DB[N] = '{8, 7, 9, 5};
  localparam int PB[N] = '{0, 1, 2, 0};
  localparam int SB[N] = '{1, 2, 1, 2};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [15:0]   cfg_div = 16'd3;
  logic [8:0]    tx_data = '0;
  logic [N-1:0]  s_ready, tx, busy, tx_done;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_cfg #(.DATA_BITS(DB[g]), .PARITY(PB[g]), .STOP_BITS(SB[g]), .DIV_W(16)) u (
      .clk(clk), .rst(rst), .cfg_div(cfg_div), .s_valid(s_valid), .s_ready(s_ready[g]),
      .tx_data(tx_data), .tx(tx[g]), .busy(busy[g]), .tx_done(tx_done[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    int          start;
    int          div;
    int          nbits;
    logic [12:0] bits;
  } frame_t;

  frame_t       q[N][$];
  int           free_at[N];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic         stall = 1'b0;
  logic         p_rst = 1'b1;
  logic [N-1:0] p_acc = '0;
  logic [8:0]   p_data = '0;
  int           p_div = 0;

  // Frame as a bit list: start, data LSB first, optional parity, stop bits.
  function automatic frame_t mk(int i, logic [8:0] d);
    frame_t f;
    logic   par;
    int     n;
    f.bits = '1;
    f.bits[0] = 1'b0;
    n = 1;
    par = 1'b0;
    for (int k = 0; k < DB[i]; k++) begin
      f.bits[n] = d[k];
      par = par ^ d[k];
      n++;
    end
    if (PB[i] != 0) begin
      f.bits[n] = (PB[i] == 1) ? par : ~par;
      n++;
    end
    f.nbits = n + SB[i];
    f.start = 0;
    f.div   = -1;
    return f;
  endfunction

  task automatic check(string name, int i, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d got=%0b exp=%0b", name, i, cyc, act, exp);
    end
  endtask

  // Monitor: cyc counts clock edges; the pre-edge inputs sampled last negedge
  // drive the model update for the edge just taken.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      frame_t f;
      logic   exp_tx, exp_done, exp_buf;
      int     st;
      if (p_rst) begin
        q[i].delete();
        free_at[i] = 0;
      end else if (p_acc[i]) begin
        f = mk(i, p_data);
        f.start = (cyc > free_at[i]) ? cyc : free_at[i];
        q[i].push_back(f);
      end
      // the divisor is fixed at the edge the frame actually loads
      for (int k = 0; k < q[i].size(); k++) begin
        if (q[i][k].div < 0 && q[i][k].start == cyc) begin
          q[i][k].div = p_div;
          free_at[i] = cyc + q[i][k].nbits * (p_div + 1);
        end
      end
      exp_done = 1'b0;
      while (q[i].size() > 0 && q[i][0].div >= 0 &&
             q[i][0].start + q[i][0].nbits * (q[i][0].div + 1) <= cyc) begin
        if (q[i][0].start + q[i][0].nbits * (q[i][0].div + 1) == cyc) exp_done = 1'b1;
        void'(q[i].pop_front());
      end
      exp_tx  = 1'b1;
      exp_buf = 1'b0;
      for (int k = 0; k < q[i].size(); k++) begin
        st = q[i][k].start;
        if (st > cyc) exp_buf = 1'b1;
        else if (q[i][k].div >= 0) exp_tx = q[i][k].bits[(cyc - st) / (q[i][k].div + 1)];
      end
      check("tx", i, tx[i], exp_tx);
      check("tx_done", i, tx_done[i], exp_done);
      check("s_ready", i, s_ready[i], !exp_buf);
      check("busy", i, busy[i], q[i].size() > 0);
    end
    check("handshake_timeout", 0, stall, 1'b0);
    p_rst  = rst;
    p_div  = int'(cfg_div);
    p_data = tx_data;
    p_acc  = {N{s_valid && !rst}} & s_ready;
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(logic [8:0] d);
    @(posedge clk); #2;
    s_valid = 1'b1;
    tx_data = d;
    @(posedge clk); #2;
    s_valid = 1'b0;
  endtask

  initial begin
    logic [8:0] seq[3];
    logic       r;
    int         guard;
    seq = '{9'h11, 9'h22, 9'h33};

    idle(3);
    rst = 1'b0;
    idle(2);

    // single frames, cfg_div=3
    pulse(9'h0A5); idle(70);
    pulse(9'h035); idle(70);
    pulse(9'h000); idle(70);
    pulse(9'h001); idle(70);

    // streaming against instance 0's handshake
    for (int j = 0; j < 3; j++) begin
      s_valid = 1'b1;
      tx_data = seq[j];
      for (guard = 0; guard < 300; guard++) begin
        r = s_ready[0];
        @(posedge clk); #2;
        if (r) break;
      end
      if (guard == 300) stall = 1'b1;
    end
    s_valid = 1'b0;
    idle(200);

    // reset in the middle of a data bit
    pulse(9'h05A);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    idle(5);
    pulse(9'h0C6); idle(70);

    // divisor change mid-frame
    pulse(9'h03C); idle(10);
    cfg_div = 16'd9;
    idle(60);
    pulse(9'h0C3); idle(150);

    // random traffic with small divisors, including 0
    cfg_div = 16'd0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #2;
      s_valid = ($urandom_range(0, 3) != 0);
      tx_data = 9'($urandom);
      if ($urandom_range(0, 59) == 0) cfg_div = 16'($urandom_range(0, 2));
    end
    s_valid = 1'b0;
    idle(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
